// File: rtl/common_pkg.sv
// Shared definitions for the object pipeline: the object record written into
// object_buffer, the stream frame header value and the frame checksum helper.
package common;

    // Header byte that opens every framed object on the host byte stream.
    localparam logic [7:0] OBJ_SYNC_BYTE = 8'hA5;

    // One object record as stored in object_buffer.
    typedef struct packed {
        logic [7:0] color;
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] shape;
    } object_t;

    // Running frame checksum: XOR of the header and every payload byte.
    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/object_stream_packer.sv
// object_stream_packer: assembles framed host bytes (SYNC, payload LSB-first,
// optional check byte) into object_t records and writes them into the object
// buffer write port, stalling while the buffer reports full.
// Build option: define OBJECT_PACKER_CHECKSUM_EN to include the check byte,
// the CHECK state and the dropped-frame error counter.
module object_stream_packer
    import common::*;
#(
    parameter int         OBJECT_BYTES = ($bits(object_t) + 7) / 8,
    parameter logic [7:0] SYNC_BYTE    = OBJ_SYNC_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        full,
    output object_t     data,
    output logic        write,
    output logic [15:0] object_count,
    output logic [15:0] error_count,
    output logic        busy
);

    localparam int REG_W = OBJECT_BYTES * 8;
    localparam int OBJ_W = $bits(object_t);
    localparam int PAD_W = (REG_W > OBJ_W) ? REG_W : OBJ_W;
    localparam int CNT_W = $clog2(OBJECT_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OBJECT_BYTES - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   byte_cnt_r;
    logic [REG_W-1:0]   shift_r;
    logic [PAD_W-1:0]   pad_s;
    logic [15:0]        object_count_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               sync_hit_s;
    logic               last_lane_s;
    logic               write_s;

    assign in_ready_s  = (state_r != WRITE);
    assign accept_s    = in_valid && in_ready_s;
    assign sync_hit_s  = accept_s && (in_data == SYNC_BYTE);
    assign last_lane_s = (byte_cnt_r == LAST_CNT);

`ifdef OBJECT_PACKER_CHECKSUM_EN
    logic [7:0]  csum_r;
    logic [15:0] error_count_r;
    logic        csum_match_s;

    assign csum_match_s = (in_data == csum_r);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and write strobe; write follows full combinationally.
    always_comb begin
        next_state_s = state_r;
        write_s      = 1'b0;
        case (state_r)
            HUNT: begin
                if (sync_hit_s) begin
                    next_state_s = PAYLOAD;
                end else begin
                    next_state_s = HUNT;
                end
            end
            PAYLOAD: begin
                if (accept_s && last_lane_s) begin
`ifdef OBJECT_PACKER_CHECKSUM_EN
                    next_state_s = CHECK;
`else
                    next_state_s = WRITE;
`endif
                end else begin
                    next_state_s = PAYLOAD;
                end
            end
`ifdef OBJECT_PACKER_CHECKSUM_EN
            CHECK: begin
                if (accept_s) begin
                    if (csum_match_s) begin
                        next_state_s = WRITE;
                    end else begin
                        next_state_s = HUNT;
                    end
                end else begin
                    next_state_s = CHECK;
                end
            end
`endif
            WRITE: begin
                write_s = !full;
                if (!full) begin
                    next_state_s = HUNT;
                end else begin
                    next_state_s = WRITE;
                end
            end
            default: begin
                next_state_s = HUNT;
                write_s      = 1'b0;
            end
        endcase
    end

    // Byte lane counter, assembly register and written-object counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            byte_cnt_r     <= '0;
            shift_r        <= '0;
            object_count_r <= 16'd0;
        end else begin
            if (state_r == HUNT && sync_hit_s) begin
                byte_cnt_r <= '0;
            end else if (state_r == PAYLOAD && accept_s) begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            end
            for (int i = 0; i < OBJECT_BYTES; i++) begin
                if (state_r == PAYLOAD && accept_s && byte_cnt_r == CNT_W'(i)) begin
                    shift_r[i*8 +: 8] <= in_data;
                end
            end
            if (write_s) begin
                object_count_r <= object_count_r + 16'd1;
            end
        end
    end

`ifdef OBJECT_PACKER_CHECKSUM_EN
    // Frame checksum and saturating count of frames dropped on mismatch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            csum_r        <= 8'h00;
            error_count_r <= 16'd0;
        end else begin
            if (state_r == HUNT && sync_hit_s) begin
                csum_r <= SYNC_BYTE;
            end else if (state_r == PAYLOAD && accept_s) begin
                csum_r <= csum_update(csum_r, in_data);
            end
            if (state_r == CHECK && accept_s && !csum_match_s && error_count_r != 16'hFFFF) begin
                error_count_r <= error_count_r + 16'd1;
            end
        end
    end

    assign error_count = error_count_r;
`else
    assign error_count = 16'd0;
`endif

    // Object view of the assembly register, zero-padded if it is narrower.
    always_comb begin
        pad_s            = '0;
        pad_s[REG_W-1:0] = shift_r;
    end

    assign data         = object_t'(pad_s[OBJ_W-1:0]);
    assign write        = write_s;
    assign in_ready     = in_ready_s;
    assign busy         = (state_r != HUNT);
    assign object_count = object_count_r;

endmodule

// File: tb/tb_object_stream_packer.sv
// Directed bench for object_stream_packer with OBJECT_BYTES=4. Works in both
// builds; the expected cycle tables include the check byte only when
// OBJECT_PACKER_CHECKSUM_EN is defined.
module tb_object_stream_packer;
    import common::*;

    typedef struct {
        logic        valid;
        logic [7:0]  din;
        logic        full;
        logic        ew;
        logic        er;
        logic        eb;
        logic        cd;
        logic [31:0] ed;
    } vec_t;

    vec_t        vecs[$];
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        full = 1'b0;
    logic        in_ready;
    object_t     data;
    logic        write;
    logic [15:0] object_count;
    logic [15:0] error_count;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    object_stream_packer #(.OBJECT_BYTES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .full         (full),
        .data         (data),
        .write        (write),
        .object_count (object_count),
        .error_count  (error_count),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic f,
                                input logic ew, input logic er, input logic eb,
                                input logic cd, input logic [31:0] ed);
        vec_t x;
        x.valid = v; x.din = d; x.full = f;
        x.ew = ew; x.er = er; x.eb = eb; x.cd = cd; x.ed = ed;
        vecs.push_back(x);
    endfunction

    // One frame: header, 4 payload bytes (optional idle cycle after lane gap),
    // check byte when enabled, 'stall' cycles of full, then the write cycle.
    function automatic void add_frame(input logic [31:0] payload, input logic [7:0] ck,
                                      input int stall, input int gap);
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            add(1'b1, payload[i*8 +: 8], 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            if (i == gap) add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        end
`ifdef OBJECT_PACKER_CHECKSUM_EN
        add(1'b1, ck, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
`endif
        for (int s = 0; s < stall; s++)
            add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, payload);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, payload);
    endfunction

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].din;
            full     = vecs[i].full;
            @(negedge clock);
            chk($sformatf("%s_%0d_write", tag, i), 32'(write), 32'(vecs[i].ew));
            chk($sformatf("%s_%0d_in_ready", tag, i), 32'(in_ready), 32'(vecs[i].er));
            chk($sformatf("%s_%0d_busy", tag, i), 32'(busy), 32'(vecs[i].eb));
            if (vecs[i].cd) chk($sformatf("%s_%0d_data", tag, i), 32'(data), vecs[i].ed);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        full     = 1'b0;
        vecs.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_write"}, 32'(write), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_object_count"}, 32'(object_count), 32'd0);
        chk({tag, "_error_count"}, 32'(error_count), 32'd0);
    endtask

    initial begin
        int exp_objs;
        int exp_errs;

        // Power-on reset.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_state("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Main table.
        add_frame(32'h44332211, 8'hE1, 0, -1);
        exp_objs = 1;
        exp_errs = 0;
`ifdef OBJECT_PACKER_CHECKSUM_EN
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add_frame(32'h44332211, 8'hE1, 0, -1);
        exp_objs += 1;
        exp_errs = 1;
`endif
        add_frame(32'h04030201, 8'hA1, 5, -1);
        add(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add_frame(32'h000000A5, 8'h00, 0, 1);
        add_frame(32'hEFBEADDE, 8'h87, 0, -1);
        exp_objs += 3;
        run_vecs("tbl");
        @(negedge clock);
        chk("tbl_object_count", 32'(object_count), 32'(exp_objs));
        chk("tbl_error_count", 32'(error_count), 32'(exp_errs));
        @(posedge clock);
        #1;

        // Reset in the middle of a frame, then a clean frame.
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        run_vecs("pre");
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk_reset_state("mid");
        @(posedge clock);
        #1;
        add_frame(32'h0DF0D00D, 8'h85, 0, -1);
        run_vecs("post");
        @(negedge clock);
        chk("post_object_count", 32'(object_count), 32'd1);
        chk("post_error_count", 32'(error_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/object_stream_packer.md
# object_stream_packer

Byte-serial front end that turns a framed host byte stream into `object_t` records and pushes them into the object buffer's write port (`data_a`/`write_a`/`full`). It is the producer end of that write interface: it assembles, optionally checks and stalls on `full`. Downstream rasterization is unaffected. It sits between the host link and `object_buffer`, in parallel with or in place of `instruction_handler`.

## Interface

Parameters:
- `OBJECT_BYTES`, default `($bits(object_t)+7)/8`: number of payload bytes per object, sent LSB-first.
- `SYNC_BYTE`, default `common::OBJ_SYNC_BYTE` (8'hA5): frame header value.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-low.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a byte this cycle when `in_valid && in_ready`.
- `full` in 1: object buffer cannot accept a write.
- `data` out `object_t`: assembled object, drives `data_a`.
- `write` out 1: one-cycle write strobe, drives `write_a`.
- `object_count` out 16: objects written since reset, wraps.
- `error_count` out 16: frames dropped on checksum mismatch, saturates at 16'hFFFF.
- `busy` out 1: high in any state other than HUNT.

## Operation

States:
- **HUNT**: an accepted byte equal to `SYNC_BYTE` seeds the checksum with `SYNC_BYTE`, clears the byte counter and moves to PAYLOAD. Any other byte is discarded.
- **PAYLOAD**: each accepted byte is stored at byte lane `byte_cnt` of an `OBJECT_BYTES*8` shift register and XORed into the checksum. When the last lane (`byte_cnt == OBJECT_BYTES-1`) is accepted, the block moves to CHECK.
- **CHECK**: the accepted byte is compared with the checksum.
  - On a match: move to WRITE.
  - On a mismatch: increment `error_count` (saturating) and return to HUNT.
- **WRITE**: `in_ready` is 0. `write = !full`. When `write` is 1, increment `object_count` and move to HUNT. While `full` is 1, hold state with `write` low.

Rules:
- `data` is the low `$bits(object_t)` bits of the register, cast to `object_t`. It is stable for the entire WRITE state.
- `in_ready` = 1 in HUNT, PAYLOAD and CHECK.
- A `SYNC_BYTE` value inside the payload or check position is treated as data, not as resync.
- `byte_cnt` has width `$clog2(OBJECT_BYTES+1)`.
- The checksum is the 8-bit XOR of the header and all payload bytes.

## Timing

- Reset values: state HUNT, `in_ready`=1, `write`=0, `busy`=0, `data`=0, `object_count`=0, `error_count`=0, checksum=0, `byte_cnt`=0.
- Latency: if the check byte is accepted at cycle t and `full`=0 at t+1, `write` is 1 in cycle t+1. `in_ready` returns to 1 at t+2.
- Throughput: one object per `OBJECT_BYTES+3` cycles when there is no stall.
- If `full` rises while in WRITE, `write` drops in the same cycle (combinational on `full`). `data` holds its value.
- `in_valid` may be low in any state; the FSM simply waits.
- If `reset` is asserted mid-frame, the partial frame is discarded. No write occurs. The counters clear.
- `object_count` wraps from 16'hFFFF to 0.

## Configuration

- `OBJECT_PACKER_CHECKSUM_EN` defined: behaviour as described above, including the CHECK state.
- Not defined:
  - The CHECK state is removed. The last payload byte moves the FSM directly to WRITE, so latency is t+1 from the last payload byte.
  - `error_count` is tied to 0.
  - No checksum logic is built.

## Structure

- `common` package gains `OBJ_SYNC_BYTE`.
- Reuses the existing `object_t` definition.
- The state enum (`HUNT`, `PAYLOAD`, `CHECK`, `WRITE`) is local to the module.
- No sub-module: shift register, counter, checksum and FSM live in one module.

## Test plan

The bench overrides `OBJECT_BYTES`=4; "low 32 bits" refers to `data`.

- Stream A5 11 22 33 44 E1 with `full`=0 → single `write` pulse one cycle after E1. Low 32 bits = 32'h44332211, `object_count`=1.
- Same stream with check byte E0 → no `write`, `error_count`=1. A following valid frame writes normally.
- Valid frame with `full`=1 for 5 cycles after the check byte → `write`=0 and `in_ready`=0 for those 5 cycles, stable `data`. Exactly one `write` in the cycle `full` drops.
- Leading garbage 00 FF 5A, then a valid frame → garbage is ignored and one write occurs. A payload containing A5 (A5 A5 00 00 00 00) → `data` low 32 bits = 32'h000000A5 and `write` asserted.
- `reset` low for one cycle after two payload bytes → all outputs at reset values. The next complete frame writes correctly.
- Build without `OBJECT_PACKER_CHECKSUM_EN`: A5 11 22 33 44 → `write` one cycle after 44, `error_count` stays 0.
